// File: rtl/apb_master_seq.sv
// Command-FIFO driven APB master: queues addr/data/dir commands and replays each
// one as an APB SETUP/ACCESS transfer with PREADY waits, timeout abort and a response pulse.
module apb_master_seq #(
  parameter int ADDRESSWIDTH   = 4,
  parameter int DATAWIDTH      = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDRESSWIDTH-1:0] cmd_addr,
  input  logic [DATAWIDTH-1:0]    cmd_wdata,
  input  logic                    cmd_write,
  output logic                    rsp_valid,
  output logic [DATAWIDTH-1:0]    rsp_rdata,
  output logic                    rsp_err,
  output logic                    busy,
  output logic [ADDRESSWIDTH-1:0] PADDR,
  output logic [DATAWIDTH-1:0]    PWDATA,
  output logic                    PWRITE,
  output logic                    PSELx,
  output logic                    PENABLE,
  input  logic [DATAWIDTH-1:0]    PRDATA,
  input  logic                    PREADY
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int EW = 1 + ADDRESSWIDTH + DATAWIDTH;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [WW-1:0]           wait_q, wait_d;
  logic [PW:0]             wr_ptr_q, rd_ptr_q;
  logic [EW-1:0]           mem_q [FIFO_DEPTH];
  logic [ADDRESSWIDTH-1:0] paddr_q;
  logic [DATAWIDTH-1:0]    pwdata_q;
  logic                    pwrite_q;
  logic                    psel_q, penable_q;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [DATAWIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;

  logic          fifo_empty, fifo_full, push, pop;
  logic [EW-1:0] head;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign push       = cmd_valid && !fifo_full;
  assign head       = mem_q[rd_ptr_q[PW-1:0]];

  always_ff @(posedge PCLK) begin
    if (push) begin
      mem_q[wr_ptr_q[PW-1:0]] <= {cmd_write, cmd_addr, cmd_wdata};
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    pop         = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = S_SETUP;
          end else begin
            state_d = S_IDLE;
          end
        end else if (wait_q == WW'(TIMEOUT_CYCLES - 1)) begin
          // Abort always returns to IDLE so the bus shows a gap after a hung slave.
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = S_IDLE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (pop) begin
      wait_d = '0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      wr_ptr_q    <= wr_ptr_q + (PW+1)'(push);
      rd_ptr_q    <= rd_ptr_q + (PW+1)'(pop);
      psel_q      <= (state_d != S_IDLE);
      penable_q   <= (state_d == S_ACCESS);
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      if (pop) begin
        {pwrite_q, paddr_q, pwdata_q} <= head;
      end
    end
  end

  assign cmd_ready = !fifo_full;
  assign busy      = !fifo_empty || (state_q != S_IDLE);
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PWRITE    = pwrite_q;
  assign PSELx     = psel_q;
  assign PENABLE   = penable_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/apb_master_seq.md
Name: apb_master_seq

Overview:
Upstream APB master that feeds apb_to_i2c_top. Accepts simple register commands (addr, data, read/write) on a valid/ready port and buffers them in a small FIFO. Replays each command as a compliant APB SETUP/ACCESS transfer with PREADY wait-state handling and a timeout. Returns a response (read data or error) per transfer, so firmware-like logic can program the I2C bridge without hand-timed APB sequences.

Parameters:
ADDRESSWIDTH, 4, APB address width (PADDR, cmd_addr)
DATAWIDTH, 8, APB data width (PWDATA, PRDATA, cmd_wdata, rsp_rdata)
FIFO_DEPTH, 4, command FIFO entries; power of 2, minimum 2
TIMEOUT_CYCLES, 16, ACCESS-phase cycles without PREADY before abort; minimum 1

Ports:
PCLK  in  1  single clock, rising edge
PRESETn  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept; equals !full, registered state only
cmd_addr  in  ADDRESSWIDTH  target register address
cmd_wdata  in  DATAWIDTH  write data; ignored for reads
cmd_write  in  1  1 = write, 0 = read
rsp_valid  out  1  one-cycle pulse per completed or aborted transfer
rsp_rdata  out  DATAWIDTH  PRDATA captured for reads; 0 for writes and errors
rsp_err  out  1  valid with rsp_valid; 1 = timeout abort
busy  out  1  FIFO non-empty or FSM not IDLE
PADDR  out  ADDRESSWIDTH  APB address
PWDATA  out  DATAWIDTH  APB write data
PWRITE  out  1  APB direction
PSELx  out  1  APB select
PENABLE  out  1  APB enable
PRDATA  in  DATAWIDTH  APB read data
PREADY  in  1  APB ready

Behaviour:
- Reset (PRESETn low, asynchronous): FIFO emptied, FSM = IDLE, wait counter 0. All outputs 0 except cmd_ready = 1. Mid-transfer reset drops PSELx/PENABLE immediately; there is no response for the aborted command.
- FIFO: push on cmd_valid && cmd_ready. Pop when the FSM loads the head into the APB output registers. Push and pop in the same cycle are both allowed, including at full: pop frees a slot only from the next cycle, because cmd_ready has no combinational passthrough. Pointers wrap modulo FIFO_DEPTH. Full/empty are tracked with an extra pointer bit or a count.
- FSM states: IDLE, SETUP, ACCESS. All APB outputs are registered.
- IDLE: PSELx = 0, PENABLE = 0. PADDR, PWDATA and PWRITE hold their last values. If the FIFO is non-empty, pop the head, load PADDR/PWDATA/PWRITE, go to SETUP.
- SETUP (exactly 1 cycle): PSELx = 1, PENABLE = 0. Next state is ACCESS.
- ACCESS: PSELx = 1, PENABLE = 1. Address, data and direction are stable for the whole transfer.
  - If PREADY = 1: the transfer completes this cycle. Next cycle: rsp_valid = 1, rsp_err = 0, rsp_rdata = PRDATA (reads) or 0 (writes).
  - On completion, if the FIFO is non-empty, pop and go directly to SETUP (PSELx stays 1, PENABLE drops to 0). Otherwise go to IDLE.
  - If PREADY = 0: increment the wait counter. When it reaches TIMEOUT_CYCLES with PREADY still 0, abort: rsp_valid = 1, rsp_err = 1, rsp_rdata = 0, go to IDLE (PSELx = 0) even if the FIFO is non-empty. The wait counter clears on every SETUP entry.
- Latency: a command accepted at edge k into an empty FIFO with FSM IDLE gives PSELx = 1 after edge k+1, PENABLE = 1 after edge k+2, and rsp_valid after edge k+3 if PREADY = 1 in the first ACCESS cycle. Back-to-back transfers cost 2 cycles each with zero wait states.
- rsp_valid has no backpressure; the consumer must sample it every cycle.
- cmd_* inputs are ignored while cmd_ready = 0.

Test Plan:
1. Single write: cmd addr 2, wdata 0xF4, write = 1, PREADY tied 1 -> PSELx high 1 cycle before PENABLE; PADDR = 2, PWDATA = 0xF4 through SETUP and ACCESS; rsp_valid pulse, rsp_err = 0, rsp_rdata = 0; busy clears.
2. Burst: addr 6 data 0x20, then eight writes to addr 4 with data 0x00..0x07, then addr 2 data 0xFC, offered continuously -> cmd_ready deasserts when 4 entries are queued. APB shows 10 transfers in order, 2 cycles each, PSELx never drops between them, 10 rsp_valid pulses.
3. Read with waits: read addr 8, PREADY low 3 ACCESS cycles then high with PRDATA = 0x5A -> PENABLE high 4 cycles, rsp_rdata = 0x5A, rsp_err = 0.
4. Timeout: read addr 2, PREADY held 0 -> after 16 ACCESS cycles rsp_err = 1, rsp_rdata = 0, PSELx = 0. A queued next command then starts from IDLE.
5. Full boundary: fill 4 entries with PREADY = 0, present a 5th -> not accepted until a pop; FIFO wrap verified over 12 commands with data 0x00..0x0B returned in order.
6. Reset mid-ACCESS with 2 commands queued: PRESETn low -> PSELx/PENABLE 0 immediately, busy = 0, cmd_ready = 1, no rsp_valid; after release, a new command executes normally.
